// File: rtl/bc_wb_dispatch_if.sv
// Write-back bus between the program sequencer / data memory and the dispatcher.
// The slave modport is the dispatcher; the master modport is the environment side.
interface bc_wb_dispatch_if #(
    parameter int DW = 16,
    parameter int AW = 4
);
    logic          ps_bc_wb_vld;
    logic [1:0]    ps_bc_wb_dst;
    logic [AW-1:0] ps_bc_wb_addr;
    logic [DW-1:0] bc_wb_dt;
    logic          bc_ps_wb_rdy;
    logic          bc_rf_we;
    logic [AW-1:0] bc_rf_addr;
    logic [DW-1:0] bc_rf_dt;
    logic          bc_dg_we;
    logic [AW-1:0] bc_dg_addr;
    logic [DW-1:0] bc_dg_dt;
    logic          bc_dm_req;
    logic          dm_bc_ack;
    logic [AW-1:0] bc_dm_addr;
    logic [DW-1:0] bc_dm_dt;
    logic          bc_wb_busy;
    logic [7:0]    bc_wb_drop_cnt;

    modport master (
        output ps_bc_wb_vld, ps_bc_wb_dst, ps_bc_wb_addr, bc_wb_dt, dm_bc_ack,
        input  bc_ps_wb_rdy, bc_rf_we, bc_rf_addr, bc_rf_dt,
        input  bc_dg_we, bc_dg_addr, bc_dg_dt,
        input  bc_dm_req, bc_dm_addr, bc_dm_dt, bc_wb_busy, bc_wb_drop_cnt
    );

    modport slave (
        input  ps_bc_wb_vld, ps_bc_wb_dst, ps_bc_wb_addr, bc_wb_dt, dm_bc_ack,
        output bc_ps_wb_rdy, bc_rf_we, bc_rf_addr, bc_rf_dt,
        output bc_dg_we, bc_dg_addr, bc_dg_dt,
        output bc_dm_req, bc_dm_addr, bc_dm_dt, bc_wb_busy, bc_wb_drop_cnt
    );
endinterface

// File: rtl/bc_wb_dispatch.sv
// Write-back dispatcher: queues {dst, addr, data} in a small FIFO and delivers each
// entry in order as an RF/DAG strobe, a DM req/ack write, or a counted discard.
module bc_wb_dispatch #(
    parameter int DW    = 16,
    parameter int AW    = 4,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    bc_wb_dispatch_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0]   CNT_FULL = (PW+1)'(DEPTH);
    localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);

    typedef enum logic [0:0] {IDLE = 1'b0, DM_WAIT = 1'b1} state_t;

    logic [1:0]    dst_mem_r  [DEPTH];
    logic [AW-1:0] addr_mem_r [DEPTH];
    logic [DW-1:0] data_mem_r [DEPTH];
    logic [PW-1:0] wr_ptr_r, rd_ptr_r;
    logic [PW:0]   count_r;

    state_t        state_r, state_nxt_s;
    logic          rdy_s, push_s, pop_s, empty_s;
    logic [1:0]    head_dst_s;
    logic [AW-1:0] head_addr_s;
    logic [DW-1:0] head_data_s;

    logic          rf_we_r, rf_we_nxt_s;
    logic [AW-1:0] rf_addr_r, rf_addr_nxt_s;
    logic [DW-1:0] rf_dt_r, rf_dt_nxt_s;
    logic          dg_we_r, dg_we_nxt_s;
    logic [AW-1:0] dg_addr_r, dg_addr_nxt_s;
    logic [DW-1:0] dg_dt_r, dg_dt_nxt_s;
    logic          dm_req_r, dm_req_nxt_s;
    logic [AW-1:0] dm_addr_r, dm_addr_nxt_s;
    logic [DW-1:0] dm_dt_r, dm_dt_nxt_s;
    logic [7:0]    drop_r, drop_nxt_s;

    // A full FIFO refuses a push even when the same edge pops an entry.
    assign rdy_s       = (count_r != CNT_FULL);
    assign empty_s     = (count_r == {(PW+1){1'b0}});
    assign push_s      = bus.ps_bc_wb_vld && rdy_s;
    assign head_dst_s  = dst_mem_r[rd_ptr_r];
    assign head_addr_s = addr_mem_r[rd_ptr_r];
    assign head_data_s = data_mem_r[rd_ptr_r];

    // FIFO storage, pointers and occupancy count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                dst_mem_r[i]  <= 2'b00;
                addr_mem_r[i] <= {AW{1'b0}};
                data_mem_r[i] <= {DW{1'b0}};
            end
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {(PW+1){1'b0}};
        end else begin
            if (push_s) begin
                dst_mem_r[wr_ptr_r]  <= bus.ps_bc_wb_dst;
                addr_mem_r[wr_ptr_r] <= bus.ps_bc_wb_addr;
                data_mem_r[wr_ptr_r] <= bus.bc_wb_dt;
                wr_ptr_r             <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Dispatch decision: next state, pop and next values of the registered outputs
    always_comb begin
        state_nxt_s   = state_r;
        pop_s         = 1'b0;
        rf_we_nxt_s   = 1'b0;
        rf_addr_nxt_s = rf_addr_r;
        rf_dt_nxt_s   = rf_dt_r;
        dg_we_nxt_s   = 1'b0;
        dg_addr_nxt_s = dg_addr_r;
        dg_dt_nxt_s   = dg_dt_r;
        dm_req_nxt_s  = 1'b0;
        dm_addr_nxt_s = dm_addr_r;
        dm_dt_nxt_s   = dm_dt_r;
        drop_nxt_s    = drop_r;
        case (state_r)
            IDLE: begin
                if (!empty_s) begin
                    case (head_dst_s)
                        2'b00: begin
                            rf_we_nxt_s   = 1'b1;
                            rf_addr_nxt_s = head_addr_s;
                            rf_dt_nxt_s   = head_data_s;
                            pop_s         = 1'b1;
                        end
                        2'b01: begin
                            dg_we_nxt_s   = 1'b1;
                            dg_addr_nxt_s = head_addr_s;
                            dg_dt_nxt_s   = head_data_s;
                            pop_s         = 1'b1;
                        end
                        2'b10: begin
                            // DM entry stays at the head until acknowledged
                            dm_req_nxt_s  = 1'b1;
                            dm_addr_nxt_s = head_addr_s;
                            dm_dt_nxt_s   = head_data_s;
                            state_nxt_s   = DM_WAIT;
                        end
                        default: begin
                            pop_s = 1'b1;
                            if (drop_r != 8'hFF) begin
                                drop_nxt_s = drop_r + 8'd1;
                            end else begin
                                drop_nxt_s = drop_r;
                            end
                        end
                    endcase
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            DM_WAIT: begin
                if (bus.dm_bc_ack) begin
                    dm_req_nxt_s = 1'b0;
                    pop_s        = 1'b1;
                    state_nxt_s  = IDLE;
                end else begin
                    dm_req_nxt_s = 1'b1;
                    state_nxt_s  = DM_WAIT;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // FSM state and registered dispatch outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            rf_we_r   <= 1'b0;
            rf_addr_r <= {AW{1'b0}};
            rf_dt_r   <= {DW{1'b0}};
            dg_we_r   <= 1'b0;
            dg_addr_r <= {AW{1'b0}};
            dg_dt_r   <= {DW{1'b0}};
            dm_req_r  <= 1'b0;
            dm_addr_r <= {AW{1'b0}};
            dm_dt_r   <= {DW{1'b0}};
            drop_r    <= 8'd0;
        end else begin
            state_r   <= state_nxt_s;
            rf_we_r   <= rf_we_nxt_s;
            rf_addr_r <= rf_addr_nxt_s;
            rf_dt_r   <= rf_dt_nxt_s;
            dg_we_r   <= dg_we_nxt_s;
            dg_addr_r <= dg_addr_nxt_s;
            dg_dt_r   <= dg_dt_nxt_s;
            dm_req_r  <= dm_req_nxt_s;
            dm_addr_r <= dm_addr_nxt_s;
            dm_dt_r   <= dm_dt_nxt_s;
            drop_r    <= drop_nxt_s;
        end
    end

    assign bus.bc_ps_wb_rdy   = rdy_s;
    assign bus.bc_rf_we       = rf_we_r;
    assign bus.bc_rf_addr     = rf_addr_r;
    assign bus.bc_rf_dt       = rf_dt_r;
    assign bus.bc_dg_we       = dg_we_r;
    assign bus.bc_dg_addr     = dg_addr_r;
    assign bus.bc_dg_dt       = dg_dt_r;
    assign bus.bc_dm_req      = dm_req_r;
    assign bus.bc_dm_addr     = dm_addr_r;
    assign bus.bc_dm_dt       = dm_dt_r;
    assign bus.bc_wb_busy     = !empty_s || (state_r == DM_WAIT);
    assign bus.bc_wb_drop_cnt = drop_r;
endmodule

// File: tb/tb_bc_wb_dispatch.sv
// Directed bench for bc_wb_dispatch; outputs are sampled 1 time unit after each
// rising edge, and inputs are changed at that same point.
module tb_bc_wb_dispatch;
    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;
    logic seen_s;

    bc_wb_dispatch_if #(.DW(16), .AW(4)) bus ();

    bc_wb_dispatch #(.DW(16), .AW(4), .DEPTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] d, input logic [3:0] a, input logic [15:0] x);
        bus.ps_bc_wb_vld  = v;
        bus.ps_bc_wb_dst  = d;
        bus.ps_bc_wb_addr = a;
        bus.bc_wb_dt      = x;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        bus.dm_bc_ack = 1'b0;
        drive(1'b0, 2'b00, 4'h0, 16'h0000);
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_rf_we",  {31'd0, bus.bc_rf_we},  32'd0);
        check_eq("rst_dm_req", {31'd0, bus.bc_dm_req}, 32'd0);
        check_eq("rst_rdy",    {31'd0, bus.bc_ps_wb_rdy}, 32'd1);
        check_eq("rst_busy",   {31'd0, bus.bc_wb_busy}, 32'd0);
        check_eq("rst_drop",   {24'd0, bus.bc_wb_drop_cnt}, 32'd0);
        check_eq("rst_rf_dt",  {16'd0, bus.bc_rf_dt}, 32'd0);
        rst_n = 1'b1;

        // single RF write
        drive(1'b1, 2'b00, 4'h3, 16'hA5A5);
        step();
        drive(1'b0, 2'b00, 4'h0, 16'h0000);
        check_eq("rf1_not_yet", {31'd0, bus.bc_rf_we}, 32'd0);
        check_eq("rf1_busy_q",  {31'd0, bus.bc_wb_busy}, 32'd1);
        step();
        check_eq("rf1_we",   {31'd0, bus.bc_rf_we}, 32'd1);
        check_eq("rf1_addr", {28'd0, bus.bc_rf_addr}, 32'h3);
        check_eq("rf1_dt",   {16'd0, bus.bc_rf_dt}, 32'hA5A5);
        check_eq("rf1_busy", {31'd0, bus.bc_wb_busy}, 32'd0);
        step();
        check_eq("rf1_we_low",  {31'd0, bus.bc_rf_we}, 32'd0);
        check_eq("rf1_hold",    {28'd0, bus.bc_rf_addr}, 32'h3);

        // back-to-back DAG writes, addrs 0..3
        for (int i = 0; i < 6; i++) begin
            if (i < 4) drive(1'b1, 2'b01, 4'(i), 16'(16'h0100 + i));
            else       drive(1'b0, 2'b00, 4'h0, 16'h0000);
            step();
            check_eq("dg_rdy", {31'd0, bus.bc_ps_wb_rdy}, 32'd1);
            if (i >= 1 && i <= 4) begin
                check_eq("dg_we",   {31'd0, bus.bc_dg_we}, 32'd1);
                check_eq("dg_addr", {28'd0, bus.bc_dg_addr}, 32'(i - 1));
                check_eq("dg_dt",   {16'd0, bus.bc_dg_dt}, 32'(16'h0100 + i - 1));
            end else begin
                check_eq("dg_we_off", {31'd0, bus.bc_dg_we}, 32'd0);
            end
        end

        // DM handshake with a trailing RF entry
        drive(1'b1, 2'b10, 4'h7, 16'h1234);
        step();
        drive(1'b1, 2'b00, 4'h5, 16'hBEEF);
        step();
        drive(1'b0, 2'b00, 4'h0, 16'h0000);
        check_eq("dm_req_up", {31'd0, bus.bc_dm_req}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            step();
            check_eq("dm_req_hold",  {31'd0, bus.bc_dm_req}, 32'd1);
            check_eq("dm_addr_hold", {28'd0, bus.bc_dm_addr}, 32'h7);
            check_eq("dm_dt_hold",   {16'd0, bus.bc_dm_dt}, 32'h1234);
            check_eq("dm_blocks_rf", {31'd0, bus.bc_rf_we}, 32'd0);
        end
        bus.dm_bc_ack = 1'b1;
        step();
        bus.dm_bc_ack = 1'b0;
        check_eq("dm_req_fall", {31'd0, bus.bc_dm_req}, 32'd0);
        check_eq("dm_bubble",   {31'd0, bus.bc_rf_we}, 32'd0);
        step();
        check_eq("dm_next_rf_we",   {31'd0, bus.bc_rf_we}, 32'd1);
        check_eq("dm_next_rf_addr", {28'd0, bus.bc_rf_addr}, 32'h5);
        check_eq("dm_next_rf_dt",   {16'd0, bus.bc_rf_dt}, 32'hBEEF);
        step();
        check_eq("dm_done_busy", {31'd0, bus.bc_wb_busy}, 32'd0);

        // ack held high: ignored while idle, then ends a minimum-length request
        bus.dm_bc_ack = 1'b1;
        drive(1'b1, 2'b10, 4'h2, 16'h0F0F);
        step();
        drive(1'b0, 2'b00, 4'h0, 16'h0000);
        check_eq("min_req_pre", {31'd0, bus.bc_dm_req}, 32'd0);
        step();
        check_eq("min_req_up",  {31'd0, bus.bc_dm_req}, 32'd1);
        check_eq("min_addr",    {28'd0, bus.bc_dm_addr}, 32'h2);
        step();
        check_eq("min_req_dn",  {31'd0, bus.bc_dm_req}, 32'd0);
        check_eq("min_busy",    {31'd0, bus.bc_wb_busy}, 32'd0);
        bus.dm_bc_ack = 1'b0;

        // full / backpressure behind a stalled DM write
        drive(1'b1, 2'b10, 4'h9, 16'h0009);
        step();
        for (int i = 1; i <= 3; i++) begin
            drive(1'b1, 2'b00, 4'(i), 16'(16'hC000 + i));
            step();
        end
        check_eq("full_rdy0", {31'd0, bus.bc_ps_wb_rdy}, 32'd0);
        drive(1'b1, 2'b00, 4'h4, 16'hC004);
        step();
        check_eq("full_rdy0_b", {31'd0, bus.bc_ps_wb_rdy}, 32'd0);
        step();
        check_eq("full_req",    {31'd0, bus.bc_dm_req}, 32'd1);
        check_eq("full_no_rf",  {31'd0, bus.bc_rf_we}, 32'd0);
        bus.dm_bc_ack = 1'b1;
        step();
        bus.dm_bc_ack = 1'b0;
        check_eq("full_rdy1",   {31'd0, bus.bc_ps_wb_rdy}, 32'd1);
        check_eq("full_req_dn", {31'd0, bus.bc_dm_req}, 32'd0);
        for (int i = 1; i <= 5; i++) begin
            step();
            drive(1'b0, 2'b00, 4'h0, 16'h0000);
            if (i <= 4) begin
                check_eq("full_rf_we",   {31'd0, bus.bc_rf_we}, 32'd1);
                check_eq("full_rf_addr", {28'd0, bus.bc_rf_addr}, 32'(i));
                check_eq("full_rf_dt",   {16'd0, bus.bc_rf_dt}, 32'(16'hC000 + i));
            end else begin
                check_eq("full_rf_end", {31'd0, bus.bc_rf_we}, 32'd0);
                check_eq("full_idle",   {31'd0, bus.bc_wb_busy}, 32'd0);
            end
        end

        // 300 discards: no strobes, counter saturates at 255
        seen_s = 1'b0;
        for (int i = 0; i < 300; i++) begin
            drive(1'b1, 2'b11, 4'(i), 16'(i));
            step();
            seen_s = seen_s | bus.bc_rf_we | bus.bc_dg_we | bus.bc_dm_req;
            if (i == 100) check_eq("drop_mid", {24'd0, bus.bc_wb_drop_cnt}, 32'd100);
        end
        drive(1'b0, 2'b00, 4'h0, 16'h0000);
        repeat (2) step();
        check_eq("drop_no_strobe", {31'd0, seen_s}, 32'd0);
        check_eq("drop_sat",       {24'd0, bus.bc_wb_drop_cnt}, 32'd255);

        // reset during DM_WAIT with 3 entries queued
        drive(1'b1, 2'b10, 4'hA, 16'h1111);
        step();
        drive(1'b1, 2'b00, 4'h1, 16'h2222);
        step();
        drive(1'b1, 2'b01, 4'h2, 16'h3333);
        step();
        drive(1'b0, 2'b00, 4'h0, 16'h0000);
        check_eq("mid_req", {31'd0, bus.bc_dm_req}, 32'd1);
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_req",  {31'd0, bus.bc_dm_req}, 32'd0);
        check_eq("mid_rst_busy", {31'd0, bus.bc_wb_busy}, 32'd0);
        check_eq("mid_rst_rdy",  {31'd0, bus.bc_ps_wb_rdy}, 32'd1);
        check_eq("mid_rst_drop", {24'd0, bus.bc_wb_drop_cnt}, 32'd0);
        repeat (2) step();
        rst_n = 1'b1;
        seen_s = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            seen_s = seen_s | bus.bc_rf_we | bus.bc_dg_we | bus.bc_dm_req | bus.bc_wb_busy;
        end
        check_eq("post_rst_quiet", {31'd0, seen_s}, 32'd0);
        check_eq("post_rst_rdy",   {31'd0, bus.bc_ps_wb_rdy}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
